// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state/owner encodings and sizing helpers shared by mem_bus_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int LINE_WORDS_DEF = 4;

    function automatic int beat_width(input int line_words);
        return $clog2(line_words);
    endfunction

    localparam int BEAT_W = beat_width(LINE_WORDS_DEF);

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - grant selector for mem_bus_arbiter; MEM_ARB_RR_EN selects round-robin over fixed D priority
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_mreq,
    input  logic       d_mreq,
    input  logic       d_mwr,
`ifdef MEM_ARB_RR_EN
    input  owner_t     last_owner,
`endif
    output arb_state_t next_state
);

    logic d_first;

    // Decide which cache wins the idle bus and which transaction it starts
    always_comb begin
        d_first = d_mreq;
`ifdef MEM_ARB_RR_EN
        // On a tie the cache that did not own the bus last time goes first
        if (i_mreq && d_mreq && (last_owner == OWN_D)) begin
            d_first = 1'b0;
        end
`endif
        next_state = IDLE;
        if (d_first) begin
            next_state = d_mwr ? DWRITE : DFILL;
        end else if (i_mreq) begin
            next_state = IFILL;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares the main-memory port between I-cache refills and D-cache refills/stores (MEM_ARB_RR_EN: round-robin)
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_mreq,
    input  logic [AW-1:0] i_maddr,
    output logic          i_mready,
    output logic          i_mlast,
    input  logic          d_mreq,
    input  logic          d_mwr,
    input  logic [AW-1:0] d_maddr,
    input  logic [DW-1:0] d_mdout,
    output logic          d_mready,
    output logic          d_mlast,
    output logic          m_req,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_dout,
    input  logic          m_ready,
    output logic          grant_i,
    output logic          grant_d
);

    localparam int            BW        = beat_width(LINE_WORDS);
    localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS * 4 - 1);
    localparam logic [AW-1:0] WORD_MASK = AW'(3);
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    arb_state_t    state_q;
    arb_state_t    pick_state;
    logic [BW-1:0] beat_q;
    logic [AW-1:0] addr_q;
    logic          owner_req;
    logic          beat_done;
    logic          final_beat;
    logic [AW-1:0] fill_addr;

`ifdef MEM_ARB_RR_EN
    owner_t        last_owner_q;
`endif

    mem_arb_pick u_pick (
        .i_mreq     (i_mreq),
        .d_mreq     (d_mreq),
        .d_mwr      (d_mwr),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner_q),
`endif
        .next_state (pick_state)
    );

    // The owner dropping its request aborts the transaction; beats only count while it is held
    assign owner_req  = (state_q == IFILL) ? i_mreq : d_mreq;
    assign beat_done  = owner_req & m_ready;
    assign final_beat = (beat_q == LAST_BEAT);
    assign fill_addr  = (addr_q & ~LINE_MASK) | AW'({beat_q, 2'b00});

    // Transaction sequencer: grant from IDLE, count burst beats, return to IDLE on last beat or abort
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            addr_q       <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_D;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= pick_state;
                    beat_q  <= '0;
                    if (pick_state == IFILL) begin
                        addr_q <= i_maddr;
                    end else if (pick_state != IDLE) begin
                        addr_q <= d_maddr;
                    end
`ifdef MEM_ARB_RR_EN
                    if (pick_state == IFILL) begin
                        last_owner_q <= OWN_I;
                    end else if (pick_state != IDLE) begin
                        last_owner_q <= OWN_D;
                    end
`endif
                end
                IFILL, DFILL: begin
                    if (!owner_req) begin
                        state_q <= IDLE;
                        beat_q  <= '0;
                    end else if (m_ready) begin
                        if (final_beat) begin
                            state_q <= IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                DWRITE: begin
                    if (!d_mreq || m_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Memory-side request and per-cache handshakes decoded from the owner state
    always_comb begin
        m_req    = 1'b0;
        m_wr     = 1'b0;
        m_addr   = '0;
        m_dout   = '0;
        i_mready = 1'b0;
        i_mlast  = 1'b0;
        d_mready = 1'b0;
        d_mlast  = 1'b0;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IFILL: begin
                m_req    = 1'b1;
                m_addr   = fill_addr;
                grant_i  = 1'b1;
                i_mready = beat_done;
                i_mlast  = beat_done & final_beat;
            end
            DFILL: begin
                m_req    = 1'b1;
                m_addr   = fill_addr;
                grant_d  = 1'b1;
                d_mready = beat_done;
                d_mlast  = beat_done & final_beat;
            end
            DWRITE: begin
                m_req    = 1'b1;
                m_wr     = 1'b1;
                m_addr   = addr_q & ~WORD_MASK;
                m_dout   = d_mdout;
                grant_d  = 1'b1;
                d_mready = beat_done;
                d_mlast  = beat_done;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter with a transaction-level model
module tb_mem_bus_arbiter;

    localparam int LW = 4;
    localparam logic [31:0] LINE_MASK = 32'(LW * 4 - 1);
    localparam int K_NONE = 0;
    localparam int K_IFILL = 1;
    localparam int K_DFILL = 2;
    localparam int K_WRITE = 3;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        i_mreq = 1'b0;
    logic [31:0] i_maddr = '0;
    logic        i_mready;
    logic        i_mlast;
    logic        d_mreq = 1'b0;
    logic        d_mwr = 1'b0;
    logic [31:0] d_maddr = '0;
    logic [31:0] d_mdout = '0;
    logic        d_mready;
    logic        d_mlast;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_dout;
    logic        m_ready = 1'b0;
    logic        grant_i;
    logic        grant_d;

    int checks = 0;
    int errors = 0;

    // transaction-level model
    int          t_kind = K_NONE;
    logic [31:0] t_addr = '0;
    int          t_words = 0;
    bit          t_last_d = 1'b1;
    bit          done_i = 1'b0;
    bit          done_d = 1'b0;

    // observation logs of the DUT
    logic [31:0] ilog[$];
    logic [31:0] dlog[$];
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    int          glog[$];
    int          n_imready = 0, n_ilast = 0, n_dmready = 0, n_dlast = 0;
    logic [31:0] ilast_addr = '0, dlast_addr = '0;
    logic        prev_gi = 1'b0, prev_gd = 1'b0;
    bit          pat[$];

    mem_bus_arbiter #(.LINE_WORDS(LW), .AW(32), .DW(32)) dut (
        .clk(clk), .clr(clr),
        .i_mreq(i_mreq), .i_maddr(i_maddr), .i_mready(i_mready), .i_mlast(i_mlast),
        .d_mreq(d_mreq), .d_mwr(d_mwr), .d_maddr(d_maddr), .d_mdout(d_mdout),
        .d_mready(d_mready), .d_mlast(d_mlast),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_ready(m_ready),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        t_kind   = K_NONE;
        t_addr   = '0;
        t_words  = 0;
        t_last_d = 1'b1;
        done_i   = 1'b0;
        done_d   = 1'b0;
    endtask

    task automatic model_step();
        bit pick_d;
        done_i = 1'b0;
        done_d = 1'b0;
        case (t_kind)
            K_NONE: begin
                pick_d = d_mreq;
`ifdef MEM_ARB_RR_EN
                if (i_mreq && d_mreq) pick_d = !t_last_d;
`endif
                t_words = 0;
                if (pick_d) begin
                    t_kind   = d_mwr ? K_WRITE : K_DFILL;
                    t_addr   = d_maddr;
                    t_last_d = 1'b1;
                end else if (i_mreq) begin
                    t_kind   = K_IFILL;
                    t_addr   = i_maddr;
                    t_last_d = 1'b0;
                end
            end
            K_IFILL, K_DFILL: begin
                if (!((t_kind == K_IFILL) ? i_mreq : d_mreq)) begin
                    t_kind = K_NONE;
                end else if (m_ready) begin
                    t_words++;
                    if (t_words == LW) begin
                        if (t_kind == K_IFILL) done_i = 1'b1;
                        else done_d = 1'b1;
                        t_kind = K_NONE;
                    end
                end
            end
            default: begin
                if (!d_mreq) begin
                    t_kind = K_NONE;
                end else if (m_ready) begin
                    t_kind = K_NONE;
                    done_d = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compare_cycle();
        logic e_req, e_wr, e_ir, e_il, e_dr, e_dl, e_gi, e_gd;
        logic [31:0] e_addr, e_dout;
        e_req = 0; e_wr = 0; e_ir = 0; e_il = 0; e_dr = 0; e_dl = 0; e_gi = 0; e_gd = 0;
        e_addr = '0; e_dout = '0;
        case (t_kind)
            K_IFILL: begin
                e_req = 1; e_gi = 1;
                e_addr = (t_addr & ~LINE_MASK) + 32'(t_words * 4);
                e_ir = i_mreq & m_ready;
                e_il = e_ir && (t_words == LW - 1);
            end
            K_DFILL: begin
                e_req = 1; e_gd = 1;
                e_addr = (t_addr & ~LINE_MASK) + 32'(t_words * 4);
                e_dr = d_mreq & m_ready;
                e_dl = e_dr && (t_words == LW - 1);
            end
            K_WRITE: begin
                e_req = 1; e_wr = 1; e_gd = 1;
                e_addr = t_addr & ~32'h3;
                e_dout = d_mdout;
                e_dr = d_mreq & m_ready;
                e_dl = e_dr;
            end
            default: e_req = 0;
        endcase
        chk("m_req", m_req, e_req);
        chk("m_wr", m_wr, e_wr);
        chk("m_addr", m_addr, e_addr);
        chk("m_dout", m_dout, e_dout);
        chk("i_mready", i_mready, e_ir);
        chk("i_mlast", i_mlast, e_il);
        chk("d_mready", d_mready, e_dr);
        chk("d_mlast", d_mlast, e_dl);
        chk("grant_i", grant_i, e_gi);
        chk("grant_d", grant_d, e_gd);
        if (i_mready) begin n_imready++; ilog.push_back(m_addr); end
        if (i_mlast) begin n_ilast++; ilast_addr = m_addr; end
        if (d_mready) begin n_dmready++; dlog.push_back(m_addr); end
        if (d_mlast) begin n_dlast++; dlast_addr = m_addr; end
        if (m_wr && d_mready) begin wlog_a.push_back(m_addr); wlog_d.push_back(m_dout); end
        if (grant_i && !prev_gi) glog.push_back(0);
        if (grant_d && !prev_gd) glog.push_back(1);
        prev_gi = grant_i;
        prev_gd = grant_d;
    endtask

    task automatic check_all_zero(input string p);
        chk({p, "_m_req"}, m_req, 0);
        chk({p, "_m_wr"}, m_wr, 0);
        chk({p, "_m_addr"}, m_addr, 0);
        chk({p, "_m_dout"}, m_dout, 0);
        chk({p, "_i_mready"}, i_mready, 0);
        chk({p, "_i_mlast"}, i_mlast, 0);
        chk({p, "_d_mready"}, d_mready, 0);
        chk({p, "_d_mlast"}, d_mlast, 0);
        chk({p, "_grant_i"}, grant_i, 0);
        chk({p, "_grant_d"}, grant_d, 0);
    endtask

    task automatic clear_logs();
        ilog.delete(); dlog.delete(); wlog_a.delete(); wlog_d.delete(); glog.delete();
        n_imready = 0; n_ilast = 0; n_dmready = 0; n_dlast = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        i_mreq = 0; d_mreq = 0; d_mwr = 0; m_ready = 0;
        clr = 1;
        model_reset();
        @(negedge clk);
        clr = 0;
    endtask

    // Hold requests until the model reports completion; m_ready from pat, else 1
    task automatic serve(input int budget);
        int n = 0;
        while ((i_mreq || d_mreq) && n < budget) begin
            @(negedge clk);
            n++;
            if (done_i) i_mreq = 0;
            if (done_d) d_mreq = 0;
            m_ready = (pat.size() > 0) ? pat.pop_front() : 1'b1;
        end
        chk("serve_finished", {i_mreq, d_mreq}, 0);
        i_mreq = 0; d_mreq = 0;
        @(negedge clk);
        m_ready = 0;
    endtask

    // model advances on each rising edge outside reset
    initial begin
        forever begin
            @(posedge clk);
            if (!clr) model_step();
        end
    end

    // compare DUT against model every cycle, away from the edge
    initial begin
        forever begin
            @(negedge clk);
            #2;
            compare_cycle();
        end
    end

    initial begin
        bit drop;
        int nsame;
        int ni;
        @(negedge clk);
        #3;
        check_all_zero("rst");
        clr = 0;

        // I-cache refill at 0x1234 with memory always ready
        clear_logs();
        @(negedge clk);
        i_mreq = 1; i_maddr = 32'h0000_1234; m_ready = 1;
        serve(30);
        chk("t1_n_imready", n_imready, 4);
        chk("t1_n_ilast", n_ilast, 1);
        chk("t1_nbeats", ilog.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_addr", ilog[k], 32'h1230 + 32'(4 * k));
        chk("t1_last_addr", ilast_addr, 32'h123C);

        // simultaneous I refill and D word store right after reset
        apply_reset();
        clear_logs();
        @(negedge clk);
        i_mreq = 1; i_maddr = 32'h40;
        d_mreq = 1; d_mwr = 1; d_maddr = 32'h80; d_mdout = 32'hDEAD_BEEF; m_ready = 1;
        serve(40);
        chk("t2_ngrants", glog.size(), 2);
`ifdef MEM_ARB_RR_EN
        chk("t2_first", glog[0], 0);
        chk("t2_second", glog[1], 1);
`else
        chk("t2_first", glog[0], 1);
        chk("t2_second", glog[1], 0);
`endif
        chk("t2_waddr", wlog_a[0], 32'h80);
        chk("t2_wdata", wlog_d[0], 32'hDEAD_BEEF);
        chk("t2_n_dlast", n_dlast, 1);
        chk("t2_n_ilast", n_ilast, 1);

        // D refill with memory stalls
        clear_logs();
        @(negedge clk);
        d_mreq = 1; d_mwr = 0; d_maddr = 32'h200; m_ready = 0;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        serve(40);
        chk("t3_n_dmready", n_dmready, 4);
        chk("t3_n_dlast", n_dlast, 1);
        for (int k = 0; k < 4; k++) chk("t3_addr", dlog[k], 32'h200 + 32'(4 * k));
        chk("t3_last_addr", dlast_addr, 32'h20C);

        // asynchronous reset in the middle of a D refill
        clear_logs();
        @(negedge clk);
        d_mreq = 1; d_mwr = 0; d_maddr = 32'h300; m_ready = 1;
        repeat (3) @(posedge clk);
        #3;
        clr = 1;
        model_reset();
        #1;
        check_all_zero("t4_async");
        chk("t4_beats_before", n_dmready, 2);
        @(negedge clk);
        clr = 0;
        clear_logs();
        serve(30);
        chk("t4_nbeats", dlog.size(), 4);
        chk("t4_restart_addr", dlog[0], 32'h300);
        chk("t4_n_dlast", n_dlast, 1);

        // I refill aborted after two beats, pending D refill follows
        clear_logs();
        @(negedge clk);
        i_mreq = 1; i_maddr = 32'h500; m_ready = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        i_mreq = 0; m_ready = 0;
        d_mreq = 1; d_mwr = 0; d_maddr = 32'h600;
        @(posedge clk);
        #2;
        chk("t5_mreq_after_abort", m_req, 0);
        serve(30);
        chk("t5_n_imready", n_imready, 2);
        chk("t5_n_ilast", n_ilast, 0);
        chk("t5_ngrants", glog.size(), 2);
        chk("t5_g0", glog[0], 0);
        chk("t5_g1", glog[1], 1);
        chk("t5_daddr", dlog[0], 32'h600);
        chk("t5_n_dlast", n_dlast, 1);

        // continuous D refills with I held
        apply_reset();
        clear_logs();
        @(negedge clk);
        i_mreq = 1; i_maddr = 32'h700;
        d_mreq = 1; d_mwr = 0; d_maddr = 32'h800; m_ready = 1;
        repeat (40) @(negedge clk);
        i_mreq = 0; d_mreq = 0; m_ready = 0;
        repeat (3) @(negedge clk);
        nsame = 0;
        ni = 0;
        foreach (glog[k]) begin
            if (glog[k] == 0) ni++;
            if (k > 0 && glog[k] == glog[k - 1]) nsame++;
        end
        chk("t6_enough_grants", glog.size() >= 6, 1);
`ifdef MEM_ARB_RR_EN
        chk("t6_first_i", glog[0], 0);
        chk("t6_alternate", nsame, 0);
        chk("t6_i_served", ni >= 3, 1);
`else
        chk("t6_i_starved", ni, 0);
`endif

        // randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drop = 0;
            if (i_mreq) begin
                if (done_i) begin
                    if ($urandom_range(0, 1) == 0) i_mreq = 0;
                    else i_maddr = $urandom;
                end else if ($urandom_range(0, 24) == 0) begin
                    i_mreq = 0;
                    drop = 1;
                end else if ($urandom_range(0, 7) == 0) begin
                    i_maddr = $urandom;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                i_mreq = 1;
                i_maddr = $urandom;
            end
            if (d_mreq) begin
                if (done_d) begin
                    if ($urandom_range(0, 1) == 0) d_mreq = 0;
                    else begin d_maddr = $urandom; d_mwr = 1'($urandom_range(0, 1)); end
                end else if ($urandom_range(0, 24) == 0) begin
                    d_mreq = 0;
                    drop = 1;
                end else if ($urandom_range(0, 7) == 0) begin
                    d_maddr = $urandom;
                    d_mwr = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_mreq = 1;
                d_maddr = $urandom;
                d_mwr = 1'($urandom_range(0, 1));
            end
            d_mdout = $urandom;
            m_ready = drop ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        i_mreq = 0; d_mreq = 0; m_ready = 0;
        repeat (4) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
